aes128_round_engine: RTL and testbench
======================================

Name: aes128_round_engine

Overview:
- Iterative AES-128 encryption datapath that sits directly upstream of sub_bytes.
- Owns the 128-bit state register, the on-the-fly key schedule and the round counter.
- Each round cycle it feeds the state through sub_bytes, ShiftRows, MixColumns and AddRoundKey, then registers the result.
- Takes a plaintext/key pair through a ready/valid handshake and returns ciphertext through a second ready/valid handshake.

Parameters:
- none. AES-128 only; NR=10 is a package constant.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  input valid; plaintext/key offered
- o_ready  out  1  engine idle; input accepted when i_start && o_ready
- i_plaintext  in  128  FIPS-197 byte 0 = [127:120]; state is column-major
- i_key  in  128  cipher key, same byte order
- o_valid  out  1  ciphertext available
- i_out_ready  in  1  consumer accepts ciphertext when o_valid && i_out_ready
- o_ciphertext  out  128  result, same byte order

Behaviour:
- Reset (async, any time, including mid-encryption):
  - FSM goes to IDLE.
  - o_ready=1, o_valid=0, o_ciphertext=0.
  - State, round key and round counter are cleared; rcon=8'h01.
  - Any in-flight block is discarded.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - o_ready=1.
  - On i_start: state<=i_plaintext^i_key, rk<=i_key, round<=1, rcon<=8'h01, go to ROUND.
- ROUND (o_ready=0, o_valid=0). Each cycle:
  - rk_next = key_step(rk, rcon).
  - state<=MixColumns(ShiftRows(SubBytes(state)))^rk_next. When round==10, MixColumns is bypassed.
  - rk<=rk_next, rcon<=xtime(rcon), round<=round+1.
  - After the round==10 edge, go to DONE.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36. xtime = left shift with conditional ^8'h1b.
- DONE:
  - o_valid=1 and o_ciphertext=state, held stable until i_out_ready is seen.
  - On i_out_ready: go to IDLE with o_valid=0 on the next cycle.
  - o_ciphertext keeps the last result until the next DONE or reset.
- Latency and throughput:
  - Accept edge E0; rounds on E1..E10; o_valid high from the cycle after E10.
  - Minimum of 12 cycles per block (E11 out-handshake, next accept at E12).
- Boundary conditions:
  - i_start in ROUND or DONE is ignored; not queued.
  - i_plaintext/i_key are sampled only at the accept edge, so later changes are harmless.
  - i_out_ready asserted while not in DONE has no effect.
  - i_start and i_out_ready both high in DONE: only the output handshake completes. The new block is accepted no earlier than the following cycle in IDLE.
  - Round counter is 4 bits; values 0 and 11-15 are unreachable. If ever decoded, treat as IDLE.
- Width rules:
  - All byte arithmetic is GF(2^8) mod 0x11b.
  - MixColumns per column: {02,03,01,01} circulant via xtime; no multipliers.

Decomposition:
- Package aes_pkg:
  - constants NR=10 and RCON0=8'h01
  - typedef byte_t (8 bits), word_t (32 bits), block_t (128 bits)
  - typedef for the FSM state enum
  - functions sbox(byte_t) using the same table as sub_bytes, xtime, shift_rows, mix_columns
- Reuse existing sub_bytes for the state path.
- One sub-module, aes_key_step, combinational: (rk, rcon) -> next round key.
  - w0'=w0^SubWord(RotWord(w3))^{rcon,24'h0}
  - w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'
  - SubWord uses aes_pkg::sbox.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, out_ready=1 -> o_valid exactly 10 cycles after accept edge, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32. After round 1, internal rk = a0fafe1788542cb123a339392a6c7605.
- All-zero key and plaintext -> ct 66e94bd4ef8a2c3b884cfa59ca342b2e. Hold i_out_ready=0 for 5 cycles -> o_valid and o_ciphertext stable throughout, o_ready=0. Release -> IDLE next cycle.
- Assert i_start continuously with a new pt/key every cycle during ROUND/DONE -> ignored; result matches the first accepted pair. Next accept occurs 12 cycles after the first.
- Assert rst at round 5 -> same cycle o_valid=0, o_ready=1, o_ciphertext=0. A fresh C.1 run afterwards yields the correct ct.
- Back-to-back C.1 then App. B with out_ready=1 -> both ciphertexts correct. rcon restarts at 01 for the second block.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers for the round engine.
package aes_pkg;

  localparam int          NR    = 10;
  localparam logic [7:0]  RCON0 = 8'h01;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  // FIPS-197 S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic byte_t sbox(input byte_t b);
    int idx;
    idx = int'(b);
    return SBOX_FLAT[2047-8*idx -: 8];
  endfunction

  // Multiply by {02} in GF(2^8) mod 0x11b.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r rotates left by r columns; byte 4c+r sits at [127-8*(4c+r) -: 8].
  function automatic block_t shift_rows(input block_t s);
    block_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  // {02,03,01,01} circulant on one column, built from xtime only.
  function automatic word_t mix_column(input word_t w);
    byte_t a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic block_t mix_columns(input block_t s);
    block_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of the AES-128 key expansion: (round key, rcon) -> next round key.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] i_rk,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_rk
);

  word_t w0, w1, w2, w3;
  word_t rot, sub, n0, n1, n2, n3;

  assign w0 = i_rk[127:96];
  assign w1 = i_rk[95:64];
  assign w2 = i_rk[63:32];
  assign w3 = i_rk[31:0];

  assign rot = {w3[23:0], w3[31:24]};

  // SubWord(RotWord(w3)), then the chained XOR across the four words.
  always_comb begin
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    n0  = w0 ^ sub ^ {i_rcon, 24'h0};
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
  end

  assign o_rk = {n0, n1, n2, n3};

endmodule

// File: rtl/sub_bytes.sv
// Byte-wise S-box substitution across the full 128-bit AES state.
module sub_bytes
  import aes_pkg::*;
(
  input  logic [127:0] i_data,
  output logic [127:0] o_data
);

  // Sixteen independent S-box lookups.
  always_comb begin
    o_data = '0;
    for (int i = 0; i < 16; i++) begin
      o_data[127-8*i -: 8] = sbox(i_data[127-8*i -: 8]);
    end
  end

endmodule

// File: rtl/aes128_round_engine.sv
// Iterative AES-128 encryptor: one round per cycle, key schedule computed on the fly.
module aes128_round_engine
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  output logic         o_ready,
  input  logic [127:0] i_plaintext,
  input  logic [127:0] i_key,
  output logic         o_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_ciphertext
);

  state_e      fsm_q, fsm_d;
  block_t      blk_q, blk_d;
  block_t      rk_q, rk_d;
  block_t      ct_q, ct_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [3:0]  round_q, round_d;

  block_t      sb_out, shifted, mixed, rk_next, round_out;
  logic        last_round, round_ok;

  sub_bytes u_sub_bytes (
    .i_data (blk_q),
    .o_data (sb_out)
  );

  aes_key_step u_key_step (
    .i_rk   (rk_q),
    .i_rcon (rcon_q),
    .o_rk   (rk_next)
  );

  assign shifted    = shift_rows(sb_out);
  assign mixed      = mix_columns(shifted);
  assign last_round = (round_q == 4'(NR));
  // Counter values outside 1..NR cannot occur in normal operation.
  assign round_ok   = (round_q != 4'd0) && (round_q <= 4'(NR));
  // The final round skips MixColumns.
  assign round_out  = (last_round ? shifted : mixed) ^ rk_next;

  // Next-state and datapath update for the three-state controller.
  always_comb begin
    fsm_d   = fsm_q;
    blk_d   = blk_q;
    rk_d    = rk_q;
    ct_d    = ct_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    case (fsm_q)
      IDLE: begin
        if (i_start) begin
          blk_d   = i_plaintext ^ i_key;
          rk_d    = i_key;
          round_d = 4'd1;
          rcon_d  = RCON0;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        if (!round_ok) begin
          fsm_d = IDLE;
        end else begin
          blk_d   = round_out;
          rk_d    = rk_next;
          rcon_d  = xtime(rcon_q);
          round_d = round_q + 4'd1;
          if (last_round) begin
            ct_d  = round_out;
            fsm_d = DONE;
          end
        end
      end
      DONE: begin
        if (i_out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State, key, counter and result registers; reset drops any block in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      blk_q   <= '0;
      rk_q    <= '0;
      ct_q    <= '0;
      rcon_q  <= RCON0;
      round_q <= 4'd0;
    end else begin
      fsm_q   <= fsm_d;
      blk_q   <= blk_d;
      rk_q    <= rk_d;
      ct_q    <= ct_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
    end
  end

  assign o_ready      = (fsm_q == IDLE);
  assign o_valid      = (fsm_q == DONE);
  assign o_ciphertext = ct_q;

endmodule

// File: tb/tb_aes128_round_engine.sv
// Directed-vector bench for aes128_round_engine with a ciphertext scoreboard.
module tb_aes128_round_engine;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk;
  logic         rst;
  logic         start;
  logic         ready;
  logic [127:0] pt;
  logic [127:0] key;
  logic         valid;
  logic         out_ready;
  logic [127:0] ct;

  int total;
  int bad;
  logic [127:0] sb_q[$];

  aes128_round_engine dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .o_ready      (ready),
    .i_plaintext  (pt),
    .i_key        (key),
    .o_valid      (valid),
    .i_out_ready  (out_ready),
    .o_ciphertext (ct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] junk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Output monitor: every completed output handshake is compared with the oldest expectation.
  always @(negedge clk) begin
    logic [127:0] e;
    if (!rst && valid && out_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output actual=%h required=none", ct);
      end else begin
        e = sb_q.pop_front();
        chk("ciphertext", ct, e);
      end
    end
  end

  task automatic run_block(input logic [127:0] p, input logic [127:0] k, input logic [127:0] e,
                           input int hold, input bit chk_rk, input logic [127:0] rk_exp);
    int n;
    chk("ready_before_accept", 128'(ready), 128'd1);
    pt    = p;
    key   = k;
    start = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    pt    = junk();
    key   = junk();
    out_ready = (hold == 0);
    chk("rcon_after_accept", 128'(dut.rcon_q), 128'h01);
    chk("ready_low_in_round", 128'(ready), 128'd0);
    n = 0;
    while (!valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1 && chk_rk) chk("rk_round1", dut.rk_q, rk_exp);
    end
    chk("latency", 128'(n), 128'd10);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        chk("hold_valid", 128'(valid), 128'd1);
        chk("hold_ct", ct, e);
        chk("hold_ready", 128'(ready), 128'd0);
        @(posedge clk);
        #1;
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("valid_low_after_out", 128'(valid), 128'd0);
    chk("idle_after_out", 128'(ready), 128'd1);
  endtask

  initial begin
    int k;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    pt        = '0;
    key       = '0;
    #1;
    chk("reset_ready", 128'(ready), 128'd1);
    chk("reset_valid", 128'(valid), 128'd0);
    chk("reset_ct", ct, 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run_block(C1_PT, C1_KEY, C1_CT, 0, 1'b0, '0);
    run_block(B_PT, B_KEY, B_CT, 0, 1'b1, B_RK1);
    run_block('0, '0, Z_CT, 5, 1'b0, '0);

    // Start held high with fresh pairs every cycle; only the first and the post-idle pair count.
    chk("ready_before_flood", 128'(ready), 128'd1);
    pt        = C1_PT;
    key       = C1_KEY;
    start     = 1'b1;
    out_ready = 1'b1;
    sb_q.push_back(C1_CT);
    @(posedge clk);
    #1;
    k = 0;
    while (!ready && k < 40) begin
      pt  = junk();
      key = junk();
      @(posedge clk);
      #1;
      k++;
    end
    chk("reaccept_spacing", 128'(k + 1), 128'd12);
    pt  = B_PT;
    key = B_KEY;
    sb_q.push_back(B_CT);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("second_accept", 128'(ready), 128'd0);
    k = 0;
    while (!valid && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("flood_second_latency", 128'(k), 128'd10);
    @(posedge clk);
    #1;

    // Reset asserted in the middle of round 5.
    pt    = C1_PT;
    key   = C1_KEY;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midreset_valid", 128'(valid), 128'd0);
    chk("midreset_ready", 128'(ready), 128'd1);
    chk("midreset_ct", ct, 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_block(C1_PT, C1_KEY, C1_CT, 0, 1'b0, '0);

    // Back-to-back blocks with the consumer always ready.
    run_block(C1_PT, C1_KEY, C1_CT, 0, 1'b0, '0);
    run_block(B_PT, B_KEY, B_CT, 0, 1'b0, '0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 128'(sb_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
